seg_scan_ctrl: RTL and testbench

Parametrised multiplexed LED segment display controller, successor to the fixed 5-digit scanner. It scans NUM_DIGITS digits from one clock using internal prescaling. It adds anti-ghosting guard time, frame-synchronous double-buffered data, per-digit flash masks and a blank mode. It sits between system logic and the board-level segment/digit drivers.

---
 rtl/seg_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Purpose: multiplexed LED segment scanner with guard blanking, frame-synchronous double-buffered data, flash and blank modes.
// Latency: outputs are registered; a slot position appears one clock after the counters reach it; new data is shown from the next frame boundary.
// Backpressure: none; data_valid is always accepted and the last strobe in a frame wins.
//
// Ports:
//   scan_clk     sole clock, rising edge
//   reset        asynchronous, active-low
//   data_in      digit i pattern at [i*SEG_W +: SEG_W]
//   data_valid   one-cycle strobe that captures data_in
//   mode         00 constant, 01 flash all, 10 masked flash, 11 blank
//   flash_mask   bit i set = digit i flashes in mode 10
//   seg_out      registered segment drive (active-low)
//   dig_sel      registered one-hot active-low digit enable
//   dig_idx      index of the slot currently on the outputs
//   frame_start  one-cycle pulse on the first clock of each new frame
//   flash_phase  0 = on half, 1 = off half
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 5,
  parameter int SEG_W        = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int FLASH_FRAMES = 64,
  parameter logic [SEG_W-1:0] BLANK = {SEG_W{1'b1}}
) (
  input  logic                          scan_clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*SEG_W-1:0]   data_in,
  input  logic                          data_valid,
  input  logic [1:0]                    mode,
  input  logic [NUM_DIGITS-1:0]         flash_mask,
  output logic [SEG_W-1:0]              seg_out,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
  output logic                          frame_start,
  output logic                          flash_phase
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(FLASH_FRAMES - 1);

  localparam logic [1:0] MODE_FLASH = 2'b01;
  localparam logic [1:0] MODE_MASK  = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  typedef enum logic {ST_GUARD, ST_DRIVE} phase_t;

  // Phase a slot opens in; with no guard time the slot starts driving at once.
  localparam phase_t ST_FIRST = (GUARD > 0) ? ST_GUARD : ST_DRIVE;

  // slot_cnt/idx_q/state_q describe the position that the next clock edge
  // places on the registered outputs.
  logic [CW-1:0]                       slot_cnt, slot_cnt_nxt;
  logic [IW-1:0]                       idx_q, idx_nxt;
  phase_t                              state_q, state_nxt;
  logic                                started;
  logic [1:0]                          mode_q, mode_eff;
  logic [NUM_DIGITS-1:0]               mask_q, mask_eff;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    active_q, active_nxt, pend_q, data_arr;
  logic                                pend_vld;
  logic [FW-1:0]                       frm_cnt;
  logic                                phase_nxt;
  logic                                slot_start, boundary;
  logic [SEG_W-1:0]                    seg_d, pat;
  logic [NUM_DIGITS-1:0]               sel_d;

  assign data_arr   = data_in;
  assign slot_start = (slot_cnt == '0);
  // The very first digit-0 slot after reset is not a frame boundary.
  assign boundary   = started && slot_start && (idx_q == '0);

  assign slot_cnt_nxt = (slot_cnt == CNT_LAST) ? '0 : slot_cnt + CW'(1);

  always_comb begin
    idx_nxt = idx_q;
    if (slot_cnt == CNT_LAST)
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // Mode and mask take their live value on the first clock of a slot and the
  // latched copy for the rest of it.
  assign mode_eff = slot_start ? mode : mode_q;
  assign mask_eff = slot_start ? flash_mask : mask_q;

  // The buffer swap and the phase toggle are used combinationally on the
  // boundary clock so that the whole new frame, including its first output
  // clock when there is no guard time, is consistent.
  always_comb begin
    active_nxt = active_q;
    if (boundary) begin
      if (data_valid)
        active_nxt = data_arr;
      else if (pend_vld)
        active_nxt = pend_q;
    end
  end

  assign phase_nxt = flash_phase ^ (boundary && (frm_cnt == FRM_LAST));

  // Slot phase FSM: next state and output pattern.
  always_comb begin
    state_nxt = state_q;
    sel_d     = {NUM_DIGITS{1'b1}};
    seg_d     = BLANK;
    pat       = active_nxt[idx_q];

    case (state_q)
      ST_GUARD: ;
      ST_DRIVE: begin
        if (mode_eff != MODE_BLANK) begin
          sel_d[idx_q] = 1'b0;
          if ((mode_eff == MODE_FLASH && phase_nxt) ||
              (mode_eff == MODE_MASK && mask_eff[idx_q] && phase_nxt))
            seg_d = BLANK;
          else
            seg_d = pat;
        end
      end
      default: ;
    endcase

    if (slot_cnt_nxt == '0)
      state_nxt = ST_FIRST;
    else if (slot_cnt_nxt == CNT_GUARD)
      state_nxt = ST_DRIVE;
  end

  always_ff @(posedge scan_clk or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      idx_q       <= '0;
      state_q     <= ST_FIRST;
      started     <= 1'b0;
      mode_q      <= '0;
      mask_q      <= '0;
      active_q    <= {NUM_DIGITS{BLANK}};
      pend_q      <= {NUM_DIGITS{BLANK}};
      pend_vld    <= 1'b0;
      frm_cnt     <= '0;
      flash_phase <= 1'b0;
      seg_out     <= BLANK;
      dig_sel     <= {NUM_DIGITS{1'b1}};
      dig_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt_nxt;
      idx_q    <= idx_nxt;
      state_q  <= state_nxt;
      started  <= 1'b1;

      if (slot_start) begin
        mode_q <= mode;
        mask_q <= flash_mask;
      end

      active_q <= active_nxt;

      // A strobe on the boundary clock goes straight to the active buffer.
      if (boundary)
        pend_vld <= 1'b0;
      if (data_valid && !boundary) begin
        pend_q   <= data_arr;
        pend_vld <= 1'b1;
      end

      if (boundary)
        frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + FW'(1);

      flash_phase <= phase_nxt;
      seg_out     <= seg_d;
      dig_sel     <= sel_d;
      dig_idx     <= idx_q;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose: directed self-checking bench for seg_scan_ctrl (5 digits, 4-clock slots, 1 guard clock, 2-frame flash).
// Latency: clock edges are numbered from 0 at the first rising edge after reset release; outputs are sampled 1 ns after each edge.
// Backpressure: none; stimulus is a linear sequence of directed steps.
module tb_seg_scan_ctrl;

  logic        scan_clk = 1'b0;
  logic        clk_run  = 1'b1;
  logic        reset;
  logic [39:0] data_in;
  logic        data_valid;
  logic [1:0]  mode;
  logic [4:0]  flash_mask;
  logic [7:0]  seg_out;
  logic [4:0]  dig_sel;
  logic [2:0]  dig_idx;
  logic        frame_start;
  logic        flash_phase;

  int n_vec = 0;
  int n_err = 0;
  int e     = -1;

  seg_scan_ctrl #(
    .NUM_DIGITS  (5),
    .SEG_W       (8),
    .SCAN_DIV    (4),
    .GUARD       (1),
    .FLASH_FRAMES(2),
    .BLANK       (8'hFF)
  ) dut (
    .scan_clk   (scan_clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .mode       (mode),
    .flash_mask (flash_mask),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .dig_idx    (dig_idx),
    .frame_start(frame_start),
    .flash_phase(flash_phase)
  );

  always begin
    #5;
    if (clk_run) scan_clk = ~scan_clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", e);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge scan_clk);
    #1;
    e++;
  endtask

  task automatic goto(int t);
    while (e < t) tick();
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic chk_slot(string tag, logic [4:0] sel, logic [7:0] seg);
    chk({tag, ".dig_sel"}, 64'(dig_sel), 64'(sel));
    chk({tag, ".seg_out"}, 64'(seg_out), 64'(seg));
  endtask

  // Pulse data_valid so that it is sampled on edge k.
  task automatic strobe(int k, logic [39:0] d);
    goto(k - 1);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    mode       = 2'b00;
    flash_mask = 5'b00000;
    #1 reset   = 1'b0;

    // Reset state.
    repeat (2) @(posedge scan_clk);
    @(negedge scan_clk);
    chk("rst.seg_out", 64'(seg_out), 64'h FF);
    chk("rst.dig_sel", 64'(dig_sel), 64'h1F);
    chk("rst.dig_idx", 64'(dig_idx), 64'h0);
    chk("rst.frame_start", 64'(frame_start), 64'h0);
    chk("rst.flash_phase", 64'(flash_phase), 64'h0);
    reset = 1'b1;
    e = -1;

    // 1: frame 0 blank, data from frame 1.
    goto(0);
    chk("s1.e0.frame_start", 64'(frame_start), 64'h0);
    chk_slot("s1.e0", 5'h1F, 8'hFF);
    goto(1);
    chk_slot("s1.e1", 5'h1E, 8'hFF);
    strobe(3, 40'h5544332211);
    goto(5);
    chk_slot("s1.e5", 5'h1D, 8'hFF);
    goto(19);
    chk("s1.e19.frame_start", 64'(frame_start), 64'h0);
    chk_slot("s1.e19", 5'h0F, 8'hFF);
    goto(20);
    chk("s1.e20.frame_start", 64'(frame_start), 64'h1);
    chk("s1.e20.dig_idx", 64'(dig_idx), 64'h0);
    chk("s1.e20.flash_phase", 64'(flash_phase), 64'h0);
    chk_slot("s1.e20", 5'h1F, 8'hFF);
    goto(21);
    chk("s1.e21.frame_start", 64'(frame_start), 64'h0);
    chk_slot("s1.e21", 5'h1E, 8'h11);
    goto(23);
    chk_slot("s1.e23", 5'h1E, 8'h11);
    goto(29);
    chk("s1.e29.dig_idx", 64'(dig_idx), 64'h2);
    chk_slot("s1.e29", 5'h1B, 8'h33);
    goto(37);
    chk("s1.e37.dig_idx", 64'(dig_idx), 64'h4);
    chk_slot("s1.e37", 5'h0F, 8'h55);

    // 2: flash all.
    mode = 2'b01;
    goto(39);
    chk("s2.e39.flash_phase", 64'(flash_phase), 64'h0);
    goto(40);
    chk("s2.e40.flash_phase", 64'(flash_phase), 64'h1);
    chk("s2.e40.frame_start", 64'(frame_start), 64'h1);
    goto(41);
    chk_slot("s2.e41", 5'h1E, 8'hFF);
    goto(49);
    chk_slot("s2.e49", 5'h1B, 8'hFF);
    goto(60);
    chk("s2.e60.flash_phase", 64'(flash_phase), 64'h1);
    goto(61);
    chk_slot("s2.e61", 5'h1E, 8'hFF);
    goto(80);
    chk("s2.e80.flash_phase", 64'(flash_phase), 64'h0);
    goto(81);
    chk_slot("s2.e81", 5'h1E, 8'h11);

    // 3: masked flash on digit 2.
    mode       = 2'b10;
    flash_mask = 5'b00100;
    goto(109);
    chk_slot("s3.e109", 5'h1B, 8'h33);
    goto(120);
    chk("s3.e120.flash_phase", 64'(flash_phase), 64'h1);
    goto(121);
    chk_slot("s3.e121", 5'h1E, 8'h11);
    goto(125);
    chk_slot("s3.e125", 5'h1D, 8'h22);
    goto(129);
    chk_slot("s3.e129", 5'h1B, 8'hFF);
    goto(133);
    chk_slot("s3.e133", 5'h17, 8'h44);
    goto(137);
    chk_slot("s3.e137", 5'h0F, 8'h55);

    // 4: double buffering.
    mode = 2'b00;
    strobe(145, 40'hEEDDCCBBAA);
    goto(149);
    chk_slot("s4.e149", 5'h1B, 8'h33);
    goto(160);
    chk("s4.e160.flash_phase", 64'(flash_phase), 64'h0);
    goto(161);
    chk_slot("s4.e161", 5'h1E, 8'hAA);
    goto(169);
    chk_slot("s4.e169", 5'h1B, 8'hCC);
    strobe(180, 40'h0102030405);
    goto(181);
    chk_slot("s4.e181", 5'h1E, 8'h05);
    strobe(185, 40'h9999999999);
    goto(189);
    chk_slot("s4.e189", 5'h1B, 8'h03);
    strobe(190, 40'h6655443322);
    goto(201);
    chk_slot("s4.e201", 5'h1E, 8'h22);
    goto(205);
    chk_slot("s4.e205", 5'h1D, 8'h33);

    // 5: switch to blank at slot clock 2.
    goto(221);
    chk_slot("s5.e221", 5'h1E, 8'h22);
    mode = 2'b11;
    goto(222);
    chk_slot("s5.e222", 5'h1E, 8'h22);
    goto(223);
    chk_slot("s5.e223", 5'h1E, 8'h22);
    goto(224);
    chk_slot("s5.e224", 5'h1F, 8'hFF);
    goto(226);
    chk_slot("s5.e226", 5'h1F, 8'hFF);
    goto(240);
    chk("s5.e240.frame_start", 64'(frame_start), 64'h1);
    goto(241);
    chk_slot("s5.e241", 5'h1F, 8'hFF);
    mode = 2'b00;
    goto(245);
    chk("s5.e245.dig_idx", 64'(dig_idx), 64'h1);
    chk_slot("s5.e245", 5'h1D, 8'h33);

    // 6: reset mid-drive with the clock stopped.
    clk_run = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    chk("s6.rst.seg_out", 64'(seg_out), 64'hFF);
    chk("s6.rst.dig_sel", 64'(dig_sel), 64'h1F);
    chk("s6.rst.dig_idx", 64'(dig_idx), 64'h0);
    #5;
    reset = 1'b1;
    #3;
    e = -1;
    clk_run = 1'b1;
    goto(0);
    chk("s6.e0.frame_start", 64'(frame_start), 64'h0);
    goto(1);
    chk_slot("s6.e1", 5'h1E, 8'hFF);
    goto(20);
    chk("s6.e20.frame_start", 64'(frame_start), 64'h1);
    goto(21);
    chk_slot("s6.e21", 5'h1E, 8'hFF);
    strobe(25, 40'h1234567890);
    goto(29);
    chk_slot("s6.e29", 5'h1B, 8'hFF);
    goto(41);
    chk_slot("s6.e41", 5'h1E, 8'h90);
    goto(45);
    chk_slot("s6.e45", 5'h1D, 8'h78);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
